// File: rtl/stutter_sched_pkg.sv
// stutter_sched_pkg
// Shared types and helpers for the stutter scheduler.
//   sched_state_e : scheduler phase (INIT, RUN, HALT)
//   MAX_COPIES    : widest copy mask the round-robin search can handle
//   firstSetFrom  : index of the first set mask bit at or after a start
//                   index, wrapping within nCopies
package stutter_sched_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } sched_state_e;

  localparam int MAX_COPIES = 32;

  // Returns 0 when no bit is set; callers only invoke it with a non-empty mask.
  function automatic int firstSetFrom(input logic [MAX_COPIES-1:0] mask,
                                      input int nCopies,
                                      input int startIdx);
    int   idx;
    int   result;
    logic found;
    result = 0;
    found  = 1'b0;
    for (int k = 0; k < MAX_COPIES; k++) begin
      idx = startIdx + k;
      if (idx >= nCopies) idx = idx - nCopies;
      if (!found && (k < nCopies) && mask[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sched_wait_counter.sv
// sched_wait_counter
// Counts consecutive stutter cycles of one program copy and raises a forced
// grant request once the copy has waited MAX_WAIT cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : counter advances only while the scheduler is in RUN
//   i_grant    : copy was granted this cycle
//   i_done     : copy is in its terminal state
//   o_forced   : copy must be granted this cycle
module sched_wait_counter #(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_grant,
  input  logic i_done,
  output logic o_forced
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_waitCnt;

  // A granted or finished copy starts a fresh wait; otherwise count up and
  // park at MAX_WAIT until the forced grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (i_en) begin
      if (i_grant || i_done) begin
        r_waitCnt <= '0;
      end else if (r_waitCnt != CNT_W'(MAX_WAIT)) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end
    end
  end

  assign o_forced = (r_waitCnt == CNT_W'(MAX_WAIT)) && !i_done;

endmodule

// File: rtl/stutter_scheduler.sv
// stutter_scheduler
// Drives the per-copy stutter inputs of N program copies for asynchronous
// hyperproperty checking, with bounded fairness and a round-robin fallback.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sched_choice : environment request, bit i = copy i should step
//   copy_done    : copy i reached its terminal state (level)
//   stutter_out  : registered, bit i = copy i holds this cycle
//   step_count   : registered saturating step counters, STEP_W bits per copy
//   all_done     : registered, every copy is done (scheduler halted)
// Build option: define STUTTER_SCHED_LOCKSTEP_EN for lockstep composition
// (every non-done copy steps every RUN cycle; choice/fairness removed).
module stutter_scheduler
  import stutter_sched_pkg::*;
#(
  parameter int N_COPIES = 2,
  parameter int MAX_WAIT = 3,
  parameter int STEP_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_COPIES-1:0]          sched_choice,
  input  logic [N_COPIES-1:0]          copy_done,
  output logic [N_COPIES-1:0]          stutter_out,
  output logic [N_COPIES*STEP_W-1:0]   step_count,
  output logic                         all_done
);

  localparam int PTR_W = $clog2(N_COPIES);

  sched_state_e                 r_state;
  sched_state_e                 w_stateNext;
  logic [PTR_W-1:0]             r_rrPtr;
  logic [PTR_W-1:0]             w_rrPtrNext;
  logic [N_COPIES-1:0]          r_stutter;
  logic [N_COPIES-1:0]          w_stutterNext;
  logic [N_COPIES*STEP_W-1:0]   r_stepCount;
  logic [N_COPIES*STEP_W-1:0]   w_stepNext;
  logic                         r_allDone;
  logic                         w_allDoneNext;
  logic [N_COPIES-1:0]          w_grant;
  logic                         w_allCopiesDone;
  logic                         w_inRun;
  logic                         w_grantActive;

  assign w_allCopiesDone = &copy_done;
  assign w_inRun         = (r_state == RUN);
  // The cycle in which everything finishes grants nothing.
  assign w_grantActive   = w_inRun && !w_allCopiesDone;

`ifdef STUTTER_SCHED_LOCKSTEP_EN
  logic w_unused;
  assign w_unused = ^sched_choice;

  always_comb begin
    w_grant     = w_grantActive ? ~copy_done : '0;
    w_rrPtrNext = r_rrPtr;
  end
`else
  logic [N_COPIES-1:0]   w_forced;
  logic [MAX_COPIES-1:0] w_liveMask;
  logic [PTR_W-1:0]      w_fbIdx;

  for (genvar i = 0; i < N_COPIES; i++) begin : g_wait
    sched_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
    ) u_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (w_inRun),
      .i_grant  (w_grant[i]),
      .i_done   (copy_done[i]),
      .o_forced (w_forced[i])
    );
  end

  // Chosen-and-live copies plus starving copies are granted; if that leaves
  // nobody, exactly one live copy is picked round-robin so progress is made.
  always_comb begin
    w_grant     = '0;
    w_rrPtrNext = r_rrPtr;
    w_liveMask  = '0;
    w_liveMask[N_COPIES-1:0] = ~copy_done;
    w_fbIdx     = PTR_W'(firstSetFrom(w_liveMask, N_COPIES, int'(r_rrPtr)));
    if (w_grantActive) begin
      w_grant = (sched_choice & ~copy_done) | w_forced;
      if (w_grant == '0) begin
        w_grant[w_fbIdx] = 1'b1;
        w_rrPtrNext = (w_fbIdx == PTR_W'(N_COPIES - 1)) ? '0 : w_fbIdx + 1'b1;
      end
    end
  end
`endif

  // Next-state logic: INIT is a single settling cycle, HALT is absorbing.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      INIT:    w_stateNext = RUN;
      RUN:     if (w_allCopiesDone) w_stateNext = HALT;
      HALT:    w_stateNext = HALT;
      default: w_stateNext = INIT;
    endcase
  end

  // Output logic: everyone holds outside RUN; counters saturate at all ones.
  always_comb begin
    w_stutterNext = w_inRun ? ~w_grant : '1;
    w_allDoneNext = (w_stateNext == HALT);
    w_stepNext    = r_stepCount;
    for (int i = 0; i < N_COPIES; i++) begin
      if (w_grant[i] && (r_stepCount[i*STEP_W +: STEP_W] != '1)) begin
        w_stepNext[i*STEP_W +: STEP_W] = r_stepCount[i*STEP_W +: STEP_W] + 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT;
      r_rrPtr     <= '0;
      r_stutter   <= '1;
      r_stepCount <= '0;
      r_allDone   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_rrPtr     <= w_rrPtrNext;
      r_stutter   <= w_stutterNext;
      r_stepCount <= w_stepNext;
      r_allDone   <= w_allDoneNext;
    end
  end

  assign stutter_out = r_stutter;
  assign step_count  = r_stepCount;
  assign all_done    = r_allDone;

endmodule

// File: tb/tb_stutter_scheduler.sv
// tb_stutter_scheduler
// Self-checking bench for stutter_scheduler (N_COPIES=2, MAX_WAIT=3,
// STEP_W=4): directed scenarios followed by random choice/done traffic,
// compared every cycle against a behavioural model of the scheduling rules.
module tb_stutter_scheduler;

  localparam int NC   = 2;
  localparam int MAXW = 3;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] sched_choice;
  logic [NC-1:0] copy_done;
  logic [NC-1:0] stutter_out;
  logic [NC*SW-1:0] step_count;
  logic          all_done;

  int checkCount;
  int failCount;

  // Model state: 0 = INIT, 1 = RUN, 2 = HALT
  int          mPhase;
  int          mWait[NC];
  int          mStep[NC];
  int          mRr;
  logic [NC-1:0] mStutter;
  logic        mAllDone;

  stutter_scheduler #(
    .N_COPIES (NC),
    .MAX_WAIT (MAXW),
    .STEP_W   (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sched_choice (sched_choice),
    .copy_done    (copy_done),
    .stutter_out  (stutter_out),
    .step_count   (step_count),
    .all_done     (all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase   = 0;
    mRr      = 0;
    mStutter = '1;
    mAllDone = 1'b0;
    for (int i = 0; i < NC; i++) begin
      mWait[i] = 0;
      mStep[i] = 0;
    end
  endtask

  // One clock edge of the scheduling rules, applied to the sampled inputs.
  task automatic modelStep(input logic [NC-1:0] ch, input logic [NC-1:0] dn);
    logic [NC-1:0] g;
    logic          found;
    int            idx;
    if (mPhase == 0) begin
      mPhase   = 1;
      mStutter = '1;
    end else if (mPhase == 2) begin
      mStutter = '1;
      mAllDone = 1'b1;
    end else if (dn == '1) begin
      mPhase   = 2;
      mAllDone = 1'b1;
      mStutter = '1;
      for (int i = 0; i < NC; i++) mWait[i] = 0;
    end else begin
      g = '0;
`ifdef STUTTER_SCHED_LOCKSTEP_EN
      g = ~dn;
`else
      for (int i = 0; i < NC; i++) begin
        if (ch[i] && !dn[i]) g[i] = 1'b1;
        if (mWait[i] == MAXW && !dn[i]) g[i] = 1'b1;
      end
      if (g == '0) begin
        found = 1'b0;
        for (int k = 0; k < NC; k++) begin
          idx = (mRr + k) % NC;
          if (!found && !dn[idx]) begin
            found  = 1'b1;
            g[idx] = 1'b1;
            mRr    = (idx + 1) % NC;
          end
        end
      end
`endif
      for (int i = 0; i < NC; i++) begin
        if (g[i]) begin
          mWait[i] = 0;
          if (mStep[i] < SMAX) mStep[i] = mStep[i] + 1;
        end else if (dn[i]) begin
          mWait[i] = 0;
        end else if (mWait[i] < MAXW) begin
          mWait[i] = mWait[i] + 1;
        end
      end
      mStutter = ~g;
    end
  endtask

  function automatic logic [31:0] modelSteps();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v = v | (32'(mStep[i]) << (i * SW));
    return v;
  endfunction

  // Drive inputs away from the edge, advance one clock, compare on negedge.
  task automatic applyStimulus(input logic [NC-1:0] ch, input logic [NC-1:0] dn);
    sched_choice = ch;
    copy_done    = dn;
    @(posedge clk);
    modelStep(ch, dn);
    @(negedge clk);
    checkOutput("stutter", 32'(stutter_out), 32'(mStutter));
    checkOutput("steps", 32'(step_count), modelSteps());
    checkOutput("allDone", 32'(all_done), 32'(mAllDone));
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstStutter", 32'(stutter_out), 32'h3);
    checkOutput("rstSteps", 32'(step_count), 32'h0);
    checkOutput("rstAllDone", 32'(all_done), 32'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NC-1:0] ch;
    logic [NC-1:0] dn;
    int r;
    checkCount   = 0;
    failCount    = 0;
    rst_n        = 1'b0;
    sched_choice = '0;
    copy_done    = '0;
    modelReset();

    repeat (2) @(negedge clk);
    checkOutput("resetStutter", 32'(stutter_out), 32'h3);
    checkOutput("resetSteps", 32'(step_count), 32'h0);
    checkOutput("resetAllDone", 32'(all_done), 32'h0);
    rst_n = 1'b1;

    // First edge after release is still INIT; the second shows a grant.
    applyStimulus(2'b01, 2'b00);
    checkOutput("initHold", 32'(stutter_out), 32'h3);
    applyStimulus(2'b01, 2'b00);
    checkOutput("firstGrant", 32'(stutter_out != 2'b11), 32'h1);

    // Constant choice of copy 0: copy 1 is forced every MAX_WAIT+1 cycles.
    repeat (12) applyStimulus(2'b01, 2'b00);

    // No choice: round-robin fallback alternates copies.
    repeat (6) applyStimulus(2'b00, 2'b00);

    // Done copy is never granted even when chosen.
    repeat (3) applyStimulus(2'b11, 2'b01);
    checkOutput("doneWins", 32'(stutter_out), 32'h1);

    // Saturation of copy 0's step counter.
    repeat (20) applyStimulus(2'b01, 2'b00);
    checkOutput("stepSat", 32'(step_count[SW-1:0]), 32'(SMAX));

    // Everything done: halt, then ignore later choices and done drops.
    applyStimulus(2'b10, 2'b11);
    checkOutput("haltAllDone", 32'(all_done), 32'h1);
    applyStimulus(2'b11, 2'b00);
    applyStimulus(2'b01, 2'b10);
    checkOutput("haltHold", 32'(stutter_out), 32'h3);

    // Reset from HALT, run a little, then reset mid-RUN.
    doReset();
    repeat (5) applyStimulus(2'($urandom_range(0, 3)), 2'b00);
    doReset();

    // Random traffic, resetting now and then once the model has halted.
    for (int n = 0; n < 400; n++) begin
      ch = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 15);
      dn = (r < 10) ? 2'b00 : (r < 13) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      applyStimulus(ch, dn);
      if (mPhase == 2 && $urandom_range(0, 3) == 0) doReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
